stage5_ex_mem_latch: RTL
========================

# stage5_ex_mem_latch

EX→MEM pipeline register for the 5-stage pipeline, built as a two-slot skid buffer so the execute stage sees a registered `ex_ready`. The head slot drives the memory stage and the memory-side inputs of the forwarding unit (`rs1_m`, `rs2_m`, `rd_m`, `reg_write_m`, `store_m`, `rd_m_data`). While an entry is held, the block snoops write-back and patches stale store data in place, so a store stalled behind a busy dcache never commits an old rs2 value.

## Interface
Parameters:
- `SNOOP_EN`, 1, enables the write-back snoop of held store data (0: store data is never modified after capture).

Ports (clock and reset first):
- `CLK`  in  1  pipeline clock; the block has one clock, and all state changes on its rising edge.
- `RST`  in  1  reset, synchronous and active-high.
- `ex_valid`  in  1  execute offers an entry.
- `ex_ready`  out  1  latch can accept; registered, equal to !skid_valid.
- `ex_entry`  in  `ex_mem_t`  rs1, rs2, rd, reg_write, store, load, alu_result, store_data (already EX-forwarded), pc.
- `flush`  in  1  squash all held entries (trap or mispredict).
- `mem_valid`  out  1  head slot valid.
- `mem_ready`  in  1  memory stage consumes the head this cycle.
- `mem_entry`  out  `ex_mem_t`  head slot contents.
- `rs1_m`, `rs2_m`, `rd_m`  out  5 each  head register indices, 0 when head is invalid.
- `reg_write_m`, `store_m`  out  1 each  head flags ANDed with `mem_valid`.
- `rd_m_data`  out  `word_t`  head alu_result, forwarded to EX.
- `reg_write_wb`  in  1  write-back write enable (snoop).
- `rd_wb`  in  5  write-back destination (snoop).
- `rd_wb_data`  in  `word_t`  write-back data (snoop).

## Operation
- Two slots: HEAD (drives outputs) and SKID. Valid state is {empty, head, head+skid}. SKID is never valid while HEAD is empty.
- Accept = `ex_valid && ex_ready`. Pop = `mem_valid && mem_ready`.
- Per-edge transitions:
  - empty + accept → head.
  - head + accept + pop → head (new entry).
  - head + accept + !pop → head+skid.
  - head + !accept + pop → empty.
  - head+skid + pop → head (HEAD ← SKID).
  - ex_ready is 0 in head+skid, so no accept can occur there.
- Flush: both valids clear on the next edge. Flush overrides a simultaneous accept and pop; the offered entry is dropped.
- Snoop (SNOOP_EN=1):
  - A slot hits when it is valid, holds a store, rs2 ≠ 0, `reg_write_wb` is high, `rd_wb == slot.rs2`, and the slot is not being loaded this cycle.
  - On a hit, the slot's store_data ← `rd_wb_data`.
  - When HEAD ← SKID coincides with a SKID hit, the snooped data moves with the entry.
  - Incoming entries are captured unmodified; EX forwarding covers them.
- Outputs are purely registered or AND-gated from slot state. No combinational path runs from `ex_*` to `mem_*`.

## Timing
- Reset values: `mem_valid` 0; `ex_ready` 1; all index outputs 0; `reg_write_m`, `store_m` 0; `mem_entry` and `rd_m_data` 0. Reset held mid-stream discards both slots, identical to flush.
- Latency: an entry accepted at edge N appears on `mem_*` in the cycle after edge N. Throughput is 1 entry per cycle while `mem_ready` is held high.
- Stall onset: `mem_ready` low with HEAD valid. One more entry is accepted into SKID, and `ex_ready` falls the cycle after that accept.
- Stall release: pop in head+skid promotes SKID at that edge. `ex_ready` returns high in the following cycle.
- A snoop hit at edge N is visible on `mem_entry.store_data` in the cycle after edge N.

## Structure
- `stage5_pipe_pkg`:
  - `ex_mem_t` packed struct;
  - `REG_ZERO` = 5'd0.
  - `word_t` is taken from `rv32i_types_pkg`.
- One sub-module, `stage5_snoop_slot`: a single entry register plus valid, load-enable, snoop compare and patch. It is instantiated twice, for HEAD and SKID. The top level holds the occupancy logic and the output gating.

## Test plan
- Stream: ex_valid=1, mem_ready=1, 4 entries (alu_result 0x10..0x13).
  - `mem_entry` shows 0x10..0x13 on consecutive cycles, one cycle after each accept.
  - `ex_ready` stays 1 throughout.
- Stall:
  - mem_ready=0 for 3 cycles while streaming: HEAD=A, SKID=B, `ex_ready`=0 from the cycle after B is accepted.
  - Release: A pops, B becomes HEAD, C is accepted in the cycle after release.
- Snoop: store in HEAD (rs2=5, store_data=0xDEAD) held with mem_ready=0, then reg_write_wb=1, rd_wb=5, rd_wb_data=0xBEEF.
  - Next cycle store_data=0xBEEF.
  - Repeat with rd_wb=0 or SNOOP_EN=0: data stays 0xDEAD.
- Snoop on SKID coincident with pop:
  - SKID store (rs2=7) hit with rd_wb_data=0x1234 in the same cycle as the pop.
  - The new HEAD carries 0x1234.
- Flush with simultaneous ex_valid and mem_ready in the head+skid state:
  - The next cycle has mem_valid=0, reg_write_m=0, rd_m=0, ex_ready=1.
  - The offered entry is not captured.
- Reset mid-stall (RST=1 for one cycle with both slots full): all outputs return to their reset values the next cycle.

Source files
------------

// File: rtl/rv32i_types_pkg.sv
// Basic RV32I scalar types shared across the pipeline.
//   word_t : one 32-bit architectural register / data word.
package rv32i_types_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] word_t;

endpackage

// File: rtl/stage5_pipe_pkg.sv
// Types and helpers for the EX->MEM pipeline register.
//   ex_mem_t    : one EX->MEM entry (indices, control flags, data, pc).
//   REG_ZERO    : x0 index; x0 is never a snoop source.
//   snoop_patch : returns the entry with store_data replaced by write-back
//                 data when the entry is a store whose rs2 matches the
//                 write-back destination.
package stage5_pipe_pkg;

    import rv32i_types_pkg::*;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       reg_write;
        logic       store;
        logic       load;
        word_t      alu_result;
        word_t      store_data;
        word_t      pc;
    } ex_mem_t;

    function automatic ex_mem_t snoop_patch(
        input ex_mem_t    e,
        input logic       en,
        input logic       we,
        input logic [4:0] rd,
        input word_t      data
    );
        ex_mem_t r;
        r = e;
        if (en && e.store && (e.rs2 != REG_ZERO) && we && (rd == e.rs2)) begin
            r.store_data = data;
        end
        return r;
    endfunction

endpackage

// File: rtl/stage5_snoop_slot.sv
// One EX->MEM entry register with its valid bit. A held store patches its
// store_data from the write-back bus when rs2 matches; a slot being loaded
// this cycle takes the load data untouched.
// Ports:
//   CLK, RST             clock, synchronous active-high reset
//   valid_nxt            occupancy for the next cycle (from top)
//   load_en, load_entry  capture a new entry at this edge
//   reg_write_wb, rd_wb, rd_wb_data  write-back snoop bus
//   valid, entry         registered slot state
module stage5_snoop_slot
    import rv32i_types_pkg::*;
    import stage5_pipe_pkg::*;
#(
    parameter bit SNOOP_EN = 1'b1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       valid_nxt,
    input  logic       load_en,
    input  ex_mem_t    load_entry,
    input  logic       reg_write_wb,
    input  logic [4:0] rd_wb,
    input  word_t      rd_wb_data,
    output logic       valid,
    output ex_mem_t    entry
);

    logic snoop_en;

    assign snoop_en = SNOOP_EN && valid && !load_en;

    always_ff @(posedge CLK) begin
        if (RST) begin
            valid <= 1'b0;
            entry <= '0;
        end else begin
            valid <= valid_nxt;
            if (load_en) begin
                entry <= load_entry;
            end else begin
                entry <= snoop_patch(entry, snoop_en, reg_write_wb, rd_wb, rd_wb_data);
            end
        end
    end

endmodule

// File: rtl/stage5_ex_mem_latch.sv
// EX->MEM pipeline register built as a two-slot skid buffer (HEAD, SKID).
// HEAD drives the memory stage and the memory-side forwarding outputs;
// ex_ready is registered so execute never sees a combinational path from
// mem_ready. Held stores are patched from write-back while they wait.
// Ports:
//   CLK, RST                       clock, synchronous active-high reset
//   ex_valid, ex_ready, ex_entry   execute-side handshake
//   flush                          squash both slots (and any offered entry)
//   mem_valid, mem_ready, mem_entry  memory-side handshake (HEAD)
//   rs1_m, rs2_m, rd_m, reg_write_m, store_m, rd_m_data  forwarding taps
//   reg_write_wb, rd_wb, rd_wb_data  write-back snoop bus
module stage5_ex_mem_latch
    import rv32i_types_pkg::*;
    import stage5_pipe_pkg::*;
#(
    parameter bit SNOOP_EN = 1'b1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       ex_valid,
    output logic       ex_ready,
    input  ex_mem_t    ex_entry,
    input  logic       flush,
    output logic       mem_valid,
    input  logic       mem_ready,
    output ex_mem_t    mem_entry,
    output logic [4:0] rs1_m,
    output logic [4:0] rs2_m,
    output logic [4:0] rd_m,
    output logic       reg_write_m,
    output logic       store_m,
    output word_t      rd_m_data,
    input  logic       reg_write_wb,
    input  logic [4:0] rd_wb,
    input  word_t      rd_wb_data
);

    logic    head_valid, skid_valid;
    logic    head_nxt, skid_nxt;
    logic    head_load, skid_load, promote;
    logic    accept, pop;
    ex_mem_t head_entry, skid_entry;
    ex_mem_t skid_fwd, head_in;

    assign accept = ex_valid && ex_ready;
    assign pop    = head_valid && mem_ready;

    // SKID is never loaded while being promoted, so its patched view is
    // exactly what it would have held after this edge.
    assign skid_fwd = snoop_patch(skid_entry, SNOOP_EN && skid_valid,
                                  reg_write_wb, rd_wb, rd_wb_data);
    assign head_in  = promote ? skid_fwd : ex_entry;

    always_comb begin
        head_nxt  = head_valid;
        skid_nxt  = skid_valid;
        head_load = 1'b0;
        skid_load = 1'b0;
        promote   = 1'b0;
        if (flush) begin
            head_nxt = 1'b0;
            skid_nxt = 1'b0;
        end else if (!head_valid) begin
            if (accept) begin
                head_nxt  = 1'b1;
                head_load = 1'b1;
            end
        end else if (!skid_valid) begin
            if (accept && pop) begin
                head_load = 1'b1;
            end else if (accept) begin
                skid_nxt  = 1'b1;
                skid_load = 1'b1;
            end else if (pop) begin
                head_nxt = 1'b0;
            end
        end else if (pop) begin
            head_load = 1'b1;
            promote   = 1'b1;
            skid_nxt  = 1'b0;
        end
    end

    stage5_snoop_slot #(.SNOOP_EN(SNOOP_EN)) u_head (
        .CLK          (CLK),
        .RST          (RST),
        .valid_nxt    (head_nxt),
        .load_en      (head_load),
        .load_entry   (head_in),
        .reg_write_wb (reg_write_wb),
        .rd_wb        (rd_wb),
        .rd_wb_data   (rd_wb_data),
        .valid        (head_valid),
        .entry        (head_entry)
    );

    stage5_snoop_slot #(.SNOOP_EN(SNOOP_EN)) u_skid (
        .CLK          (CLK),
        .RST          (RST),
        .valid_nxt    (skid_nxt),
        .load_en      (skid_load),
        .load_entry   (ex_entry),
        .reg_write_wb (reg_write_wb),
        .rd_wb        (rd_wb),
        .rd_wb_data   (rd_wb_data),
        .valid        (skid_valid),
        .entry        (skid_entry)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            ex_ready <= 1'b1;
        end else begin
            ex_ready <= !skid_nxt;
        end
    end

    assign mem_valid   = head_valid;
    assign mem_entry   = head_entry;
    assign rs1_m       = head_valid ? head_entry.rs1 : REG_ZERO;
    assign rs2_m       = head_valid ? head_entry.rs2 : REG_ZERO;
    assign rd_m        = head_valid ? head_entry.rd  : REG_ZERO;
    assign reg_write_m = head_valid && head_entry.reg_write;
    assign store_m     = head_valid && head_entry.store;
    assign rd_m_data   = head_entry.alu_result;

endmodule
